// File: rtl/data_sram_responder_if.sv
// Data-SRAM request/response bundle between the EX/MEM pipeline and the responder.
// master drives requests and sees rdata/stall; slave is the SRAM responder side.
interface data_sram_responder_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq_mem;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata,
        input  stallreq_mem
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata,
        output stallreq_mem
    );
endinterface

// File: rtl/data_sram_responder.sv
// Data-SRAM slave: word array fed by an in-order store buffer, loads forward buffered bytes.
// Latency: load data registered, visible the cycle after acceptance; stores retire into the buffer.
// Backpressure: stallreq_mem whenever a request arrives while the buffer is full. Optional DSRAM_STORE_COALESCE_EN.
module data_sram_responder #(
    parameter int ADDR_W   = 10,
    parameter int SB_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    data_sram_responder_if.slave          bus,
    output logic [$clog2(SB_DEPTH+1)-1:0] sb_count,
    output logic                          sb_empty
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [31:0]       dat;
        logic [3:0]        wen;
    } sb_ent_t;

    sb_ent_t             sb_q [SB_DEPTH];
    logic [SB_DEPTH-1:0] sb_vld;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [31:0]         mem [0:(1<<ADDR_W)-1];

    logic [ADDR_W-1:0]   req_idx;
    logic                full;
    logic                rd_acc;
    logic                st_acc;
    logic                drain;
    logic                merge;
    logic                alloc;
    logic [31:0]         fwd_dat;
    logic                unused_addr_bits;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SB_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign req_idx          = bus.data_sram_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0]};

    // While full, the array port is reserved for the drain, so reads stall too.
    assign full             = (sb_count == CNT_W'(SB_DEPTH));
    assign bus.stallreq_mem = bus.data_sram_en & full;
    assign rd_acc           = bus.data_sram_en & (bus.data_sram_wen == 4'b0000) & ~full;
    assign st_acc           = bus.data_sram_en & (bus.data_sram_wen != 4'b0000) & ~full;
    assign drain            = (sb_count != '0) & ~rd_acc;
    assign sb_empty         = (sb_count == '0);

`ifdef DSRAM_STORE_COALESCE_EN
    logic [PTR_W-1:0] youngest;

    assign youngest = (tail == '0) ? PTR_W'(SB_DEPTH - 1) : tail - 1'b1;
    // The head entry leaving this cycle cannot absorb a store.
    assign merge    = st_acc & (sb_count != '0) & (sb_q[youngest].idx == req_idx)
                    & ~(drain & (youngest == head));
`else
    assign merge    = 1'b0;
`endif

    assign alloc = st_acc & ~merge;

    // Walk slots from head so newer matching entries overwrite older lanes.
    always_comb begin
        logic [PTR_W-1:0] pos;
        fwd_dat = mem[req_idx];
        pos     = head;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_vld[pos] && (sb_q[pos].idx == req_idx)) begin
                for (int k = 0; k < 4; k++) begin
                    if (sb_q[pos].wen[k]) begin
                        fwd_dat[8*k +: 8] = sb_q[pos].dat[8*k +: 8];
                    end
                end
            end
            pos = ptr_inc(pos);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.data_sram_rdata <= '0;
            head                <= '0;
            tail                <= '0;
            sb_count            <= '0;
            sb_vld              <= '0;
        end else begin
            if (rd_acc) begin
                bus.data_sram_rdata <= fwd_dat;
            end
            if (drain) begin
                head <= ptr_inc(head);
            end
            if (alloc) begin
                tail <= ptr_inc(tail);
            end
            case ({alloc, drain})
                2'b10:   sb_count <= sb_count + 1'b1;
                2'b01:   sb_count <= sb_count - 1'b1;
                default: sb_count <= sb_count;
            endcase
            for (int i = 0; i < SB_DEPTH; i++) begin
                if (drain && (head == PTR_W'(i))) begin
                    sb_vld[i] <= 1'b0;
                end
                if (alloc && (tail == PTR_W'(i))) begin
                    sb_vld[i] <= 1'b1;
                end
            end
        end
    end

    // Entry payloads carry no reset; sb_vld alone says whether a slot is live.
    always_ff @(posedge clk) begin
        if (alloc) begin
            sb_q[tail] <= '{idx: req_idx, dat: bus.data_sram_wdata, wen: bus.data_sram_wen};
        end
`ifdef DSRAM_STORE_COALESCE_EN
        if (merge) begin
            sb_q[youngest].wen <= sb_q[youngest].wen | bus.data_sram_wen;
            for (int k = 0; k < 4; k++) begin
                if (bus.data_sram_wen[k]) begin
                    sb_q[youngest].dat[8*k +: 8] <= bus.data_sram_wdata[8*k +: 8];
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (drain) begin
            for (int k = 0; k < 4; k++) begin
                if (sb_q[head].wen[k]) begin
                    mem[sb_q[head].idx][8*k +: 8] <= sb_q[head].dat[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized bench for data_sram_responder: queue-based store-buffer model, decoupled rdata scoreboard.
module tb_data_sram_responder;

    localparam int ADDR_W   = 10;
    localparam int SB_DEPTH = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] sb_count;
    logic       sb_empty;

    always #5 clk = ~clk;

    data_sram_responder_if bus();

    data_sram_responder #(.ADDR_W(ADDR_W), .SB_DEPTH(SB_DEPTH)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .sb_count (sb_count),
        .sb_empty (sb_empty)
    );

    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic [31:0]       dat;
        logic [3:0]        wen;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_mem [int unsigned];
    logic [31:0] exp_q[$];
    logic [31:0] hold_exp = 32'h0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] overlay(input logic [31:0] w, input ent_t e);
        logic [31:0] r = w;
        for (int k = 0; k < 4; k++) if (e.wen[k]) r[8*k +: 8] = e.dat[8*k +: 8];
        return r;
    endfunction

    // Reference behaviour for one clock edge, given this cycle's request.
    task automatic model_step(input logic en, input logic [3:0] wen,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic stall);
        logic [ADDR_W-1:0] idx = addr[ADDR_W+1:2];
        logic rd = en && (wen == 4'b0) && !stall;
        logic st = en && (wen != 4'b0) && !stall;
        logic dr = (m_q.size() > 0) && !rd;
        logic mg = 1'b0;
        ent_t e;
        if (rd) begin
            logic [31:0] w = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
            foreach (m_q[i]) if (m_q[i].idx == idx) w = overlay(w, m_q[i]);
            exp_q.push_back(w);
        end
`ifdef DSRAM_STORE_COALESCE_EN
        mg = st && (m_q.size() > 0) && (m_q[$].idx == idx) && !(dr && m_q.size() == 1);
`endif
        if (dr) begin
            e = m_q.pop_front();
            m_mem[e.idx] = overlay(m_mem.exists(e.idx) ? m_mem[e.idx] : 32'h0, e);
        end
        if (st) begin
            if (mg) begin
                e = '{idx: idx, dat: wdata, wen: wen};
                m_q[$].dat = overlay(m_q[$].dat, e);
                m_q[$].wen = m_q[$].wen | wen;
            end else begin
                m_q.push_back('{idx: idx, dat: wdata, wen: wen});
            end
        end
    endtask

    // Presents one request, retrying while stalled (bounded).
    task automatic cycle(input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
        logic exp_stall;
        for (int tries = 0; tries < 20; tries++) begin
            @(posedge clk);
            #1;
            bus.data_sram_en    = en;
            bus.data_sram_wen   = wen;
            bus.data_sram_addr  = addr;
            bus.data_sram_wdata = wdata;
            #1;
            exp_stall = en && (m_q.size() == SB_DEPTH);
            check("stallreq_mem", {31'b0, bus.stallreq_mem}, {31'b0, exp_stall});
            check("sb_count", {29'b0, sb_count}, m_q.size());
            check("sb_empty", {31'b0, sb_empty}, {31'b0, m_q.size() == 0});
            model_step(en, wen, addr, wdata, exp_stall);
            if (!exp_stall) return;
        end
        total++;
        bad++;
        $display("FAIL stall_timeout: request still stalled after 20 cycles addr=%h", addr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] rnd_addr(input int idx);
        return ($urandom & 32'hFFFF_F000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
    endfunction

    // Scoreboard monitor: watches the handshake, compares rdata on the following cycle.
    initial begin
        logic pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rdata_unexpected: got %h with no expected entry", bus.data_sram_rdata);
                end else begin
                    hold_exp = exp_q.pop_front();
                    check("rdata", bus.data_sram_rdata, hold_exp);
                end
            end else begin
                check("rdata_hold", bus.data_sram_rdata, hold_exp);
            end
            pend = resetn && bus.data_sram_en && (bus.data_sram_wen == 4'b0) && !bus.stallreq_mem;
        end
    end

    initial begin
        bus.data_sram_en    = 1'b0;
        bus.data_sram_wen   = 4'h0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;
        #22;
        resetn = 1'b1;

        for (int i = 0; i < 16; i++) cycle(1'b1, 4'hF, rnd_addr(i), $urandom);
        cycle(1'b1, 4'hF, 32'h80, 32'hFFFF_FFFF);

        // Full-word store then read back
        cycle(1'b1, 4'hF, 32'h40, 32'h1122_3344);
        cycle(1'b1, 4'h0, 32'h40, 32'h0);
        idle(2);

        // Single-lane store forwarded over an older array word
        cycle(1'b1, 4'b0010, 32'h80, 32'h0000_AB00);
        cycle(1'b1, 4'h0, 32'h82, 32'h0);
        idle(1);

        // Back-to-back stores
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'hF, rnd_addr(i), $urandom);

        // Complementary half-word stores to one word
        cycle(1'b1, 4'b0011, 32'h100, 32'h0000_BEEF);
        cycle(1'b1, 4'b1100, 32'h100, 32'hCAFE_0000);
        cycle(1'b1, 4'h0, 32'h100, 32'h0);
        idle(1);

        // Stores in flight when reset hits
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'hF, rnd_addr(i), $urandom);
        @(posedge clk);
        #1;
        bus.data_sram_en = 1'b0;
        #2;
        resetn = 1'b0;
        m_q.delete();
        hold_exp = 32'h0;
        #1;
        check("reset_rdata", bus.data_sram_rdata, 32'h0);
        check("reset_sb_count", {29'b0, sb_count}, 32'd0);
        check("reset_sb_empty", {31'b0, sb_empty}, 32'd1);
        #3;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'h0, rnd_addr(i), 32'h0);

        // Reads interleaved with stores, then idle to empty
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 4'hF, rnd_addr(i + 4), $urandom);
            cycle(1'b1, 4'h0, rnd_addr(i + 4), 32'h0);
            cycle(1'b1, 4'h0, rnd_addr(i), 32'h0);
        end
        idle(2);

        for (int n = 0; n < 600; n++) begin
            int r = $urandom_range(0, 9);
            int idx = $urandom_range(0, 15);
            if (r < 2)      idle(1);
            else if (r < 6) cycle(1'b1, 4'h0, rnd_addr(idx), 32'h0);
            else            cycle(1'b1, 4'($urandom_range(1, 15)), rnd_addr(idx), $urandom);
        end

        idle(3);
        for (int i = 0; i < 16; i++) cycle(1'b1, 4'h0, rnd_addr(i), 32'h0);
        idle(3);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
